// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer for the single-issue core: phase code, PC,
// fetch/data handshakes, retired-instruction count, halt and bus-timeout error.
module core_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt_req,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  input  logic        is_load,
  input  logic        is_store,
  output logic        dmem_req,
  input  logic        dmem_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic [2:0]  state,
  output logic        halted,
  output logic        bus_err,
  output logic [31:0] instret
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  // Count value seen on the last permitted wait cycle; ready on that cycle still wins.
  localparam logic [15:0] TIMEOUT_LAST = 16'(MEM_TIMEOUT - 32'd1);

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] next_pc_q, next_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instret_q, instret_d;
  logic        bus_err_q, bus_err_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        waiting_s;
  logic        entering_wait_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          state_d = S_DECODE;
        end else if (wait_cnt_q == TIMEOUT_LAST) begin
          state_d = S_ERR;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (branch_taken && (branch_target[1:0] != 2'b00)) begin
          state_d = S_ERR;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ready) begin
          state_d = S_WB;
        end else if (wait_cnt_q == TIMEOUT_LAST) begin
          state_d = S_ERR;
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB: begin
        if (halt_req) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        if (halt_req) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    halted   = 1'b0;
    case (state_q)
      S_FETCH: imem_req = 1'b1;
      S_MEM:   dmem_req = 1'b1;
      S_HALT:  halted   = 1'b1;
      default: begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        halted   = 1'b0;
      end
    endcase
  end

  // Datapath: PC, redirect target, instruction latch, retire counter, wait counter.
  always_comb begin
    pc_d      = pc_q;
    next_pc_d = next_pc_q;
    instr_d   = instr_q;
    instret_d = instret_q;
    bus_err_d = bus_err_q | (state_d == S_ERR);

    if ((state_q == S_FETCH) && imem_ready) begin
      instr_d = imem_rdata;
    end else begin
      instr_d = instr_q;
    end

    if (state_q == S_EXEC) begin
      next_pc_d = branch_taken ? branch_target : (pc_q + 32'd4);
    end else begin
      next_pc_d = next_pc_q;
    end

    if (state_q == S_WB) begin
      pc_d      = next_pc_q;
      instret_d = instret_q + 32'd1;
    end else begin
      pc_d      = pc_q;
      instret_d = instret_q;
    end
  end

  assign waiting_s       = ((state_q == S_FETCH) && !imem_ready) ||
                           ((state_q == S_MEM) && !dmem_ready);
  assign entering_wait_s = (state_d != state_q) &&
                           ((state_d == S_FETCH) || (state_d == S_MEM));

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (entering_wait_s) begin
      wait_cnt_d = 16'd0;
    end else if (waiting_s) begin
      wait_cnt_d = wait_cnt_q + 16'd1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      next_pc_q  <= RESET_PC;
      instr_q    <= 32'd0;
      instret_q  <= 32'd0;
      bus_err_q  <= 1'b0;
      wait_cnt_q <= 16'd0;
    end else begin
      pc_q       <= pc_d;
      next_pc_q  <= next_pc_d;
      instr_q    <= instr_d;
      instret_q  <= instret_d;
      bus_err_q  <= bus_err_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign instret   = instret_q;
  assign bus_err   = bus_err_q;
  assign state     = state_q;

endmodule
